// File: rtl/sram_test_pkg.sv
// ============================================================================
// Module : sram_test_pkg
// Brief  : Shared state encoding, default widths and test pattern function
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sram_test_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    GAP      = 3'd5,
    DONE     = 3'd6
  } state_t;

  // Folds all address bits into the byte so adjacent 256-byte pages differ.
  function automatic logic [7:0] pat(input logic [18:0] addr, input logic [7:0] seed);
    return addr[7:0] ^ addr[15:8] ^ {5'b0, addr[18:16]} ^ seed;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_test_checker.sv
// ============================================================================
// Module : sram_test_checker
// Brief  : Read-data compare, saturating error counter, first-error capture
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_test_checker #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 cmp_en,
  input  logic [DATA_W-1:0]    actual,
  input  logic [DATA_W-1:0]    expected,
  input  logic [ADDR_W-1:0]    addr,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    first_err_addr
);

  assign mismatch = cmp_en && (actual != expected);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (clear) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (mismatch) begin
      if (err_count != '1)
        err_count <= err_count + 1'b1;
      if (err_count == '0)
        first_err_addr <= addr;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_test_sequencer.sv
// ============================================================================
// Module : sram_test_sequencer
// Brief  : Write-then-verify sweep of an SRAM address window via the controller.
//          Define SRAM_TEST_STOP_ON_FAIL_EN to end the test on the first mismatch.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_test_sequencer
  import sram_test_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TIMEOUT   = 16,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [ADDR_W-1:0]    addr_lo,
  input  logic [ADDR_W-1:0]    addr_hi,
  input  logic [DATA_W-1:0]    seed,
  output logic                 start_operation,
  output logic                 rw,
  output logic [ADDR_W-1:0]    address,
  output logic [DATA_W-1:0]    data_f2s,
  input  logic [DATA_W-1:0]    data_s2f,
  input  logic                 data_ready,
  input  logic                 writing_finished,
  input  logic                 busy_ctrl,
  output logic                 test_busy,
  output logic                 test_done,
  output logic                 test_pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic                 timeout_err
);

  localparam int         c_TMR_W     = $clog2(TIMEOUT + 1);
  // Issue allowed once this many cycles have elapsed since the previous start (6 apart).
  localparam logic [2:0] c_SPACE_MIN = 3'd5;

  state_t              r_state;
  state_t              r_next;
  logic [ADDR_W-1:0]   r_cur;
  logic [ADDR_W-1:0]   r_lo;
  logic [ADDR_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_seed;
  logic [c_TMR_W-1:0]  r_timer;
  logic [2:0]          r_since;
  logic [DATA_W-1:0]   w_pat;
  logic                w_mismatch;
  logic                w_clear;
  logic                w_cmp_en;

  assign w_pat    = DATA_W'(pat(19'(r_cur), 8'(r_seed)));
  assign w_clear  = (r_state == IDLE) && run;
  assign w_cmp_en = (r_state == RD_WAIT) && data_ready;

  sram_test_checker #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_checker (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (w_clear),
    .cmp_en         (w_cmp_en),
    .actual         (data_s2f),
    .expected       (w_pat),
    .addr           (r_cur),
    .mismatch       (w_mismatch),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_next          <= IDLE;
      r_cur           <= '0;
      r_lo            <= '0;
      r_hi            <= '0;
      r_seed          <= '0;
      r_timer         <= '0;
      r_since         <= '1;
      start_operation <= 1'b0;
      rw              <= 1'b0;
      address         <= '0;
      data_f2s        <= '0;
      test_busy       <= 1'b0;
      test_done       <= 1'b0;
      test_pass       <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      start_operation <= 1'b0;
      test_done       <= 1'b0;
      if (r_since != '1)
        r_since <= r_since + 1'b1;

      case (r_state)
        IDLE: begin
          if (run) begin
            r_lo        <= addr_lo;
            r_hi        <= addr_hi;
            r_seed      <= seed;
            r_cur       <= addr_lo;
            timeout_err <= 1'b0;
            test_busy   <= 1'b1;
            r_state     <= (addr_hi < addr_lo) ? DONE : WR_ISSUE;
          end
        end

        WR_ISSUE, RD_ISSUE: begin
          if (!busy_ctrl && (r_since >= c_SPACE_MIN)) begin
            start_operation <= 1'b1;
            rw              <= (r_state == RD_ISSUE);
            address         <= r_cur;
            if (r_state == WR_ISSUE)
              data_f2s <= w_pat;
            r_since <= '0;
            r_timer <= '0;
            r_state <= (r_state == WR_ISSUE) ? WR_WAIT : RD_WAIT;
          end
        end

        WR_WAIT: begin
          if (writing_finished) begin
            r_state <= GAP;
            if (r_cur == r_hi) begin
              r_cur  <= r_lo;
              r_next <= RD_ISSUE;
            end else begin
              r_cur  <= r_cur + 1'b1;
              r_next <= WR_ISSUE;
            end
          end else if (r_timer == c_TMR_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        RD_WAIT: begin
          if (data_ready) begin
`ifdef SRAM_TEST_STOP_ON_FAIL_EN
            if (w_mismatch) begin
              r_state <= DONE;
            end else if (r_cur == r_hi) begin
`else
            if (r_cur == r_hi) begin
`endif
              r_state <= GAP;
              r_next  <= DONE;
            end else begin
              r_state <= GAP;
              r_cur   <= r_cur + 1'b1;
              r_next  <= RD_ISSUE;
            end
          end else if (r_timer == c_TMR_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        GAP: r_state <= r_next;

        DONE: begin
          test_done <= 1'b1;
          test_pass <= (err_count == '0) && !timeout_err;
          test_busy <= 1'b0;
          r_state   <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_test_sequencer.sv
// ============================================================================
// Module : tb_sram_test_sequencer
// Brief  : Randomized bench with behavioural controller/SRAM and result model
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_test_sequencer;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic [AW-1:0] addr_lo = '0;
  logic [AW-1:0] addr_hi = '0;
  logic [DW-1:0] seed = '0;
  logic          start_operation;
  logic          rw;
  logic [AW-1:0] address;
  logic [DW-1:0] data_f2s;
  logic [DW-1:0] data_s2f = '0;
  logic          data_ready = 1'b0;
  logic          writing_finished = 1'b0;
  logic          busy_ctrl = 1'b0;
  logic          test_busy;
  logic          test_done;
  logic          test_pass;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_addr;
  logic          timeout_err;

  always #5 clk = ~clk;

  sram_test_sequencer #(
    .ADDR_W (AW), .DATA_W (DW), .TIMEOUT (TO), .ERR_CNT_W (EW)
  ) dut (
    .clk (clk), .reset_n (reset_n), .run (run),
    .addr_lo (addr_lo), .addr_hi (addr_hi), .seed (seed),
    .start_operation (start_operation), .rw (rw), .address (address),
    .data_f2s (data_f2s), .data_s2f (data_s2f), .data_ready (data_ready),
    .writing_finished (writing_finished), .busy_ctrl (busy_ctrl),
    .test_busy (test_busy), .test_done (test_done), .test_pass (test_pass),
    .err_count (err_count), .first_err_addr (first_err_addr),
    .timeout_err (timeout_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_pat(input int a, input logic [7:0] s);
    logic [18:0] x;
    x = a[18:0];
    return x[7:0] ^ x[15:8] ^ {5'b0, x[18:16]} ^ s;
  endfunction

  // Behavioural controller + byte SRAM; stuck-at-zero read faults; optional hung writes.
  logic [7:0] mem [int];
  bit         faulty [int];
  bit         hang_wr = 1'b0;
  bit         ctl_busy = 1'b0;
  bit         ctl_rw = 1'b0;
  int         ctl_addr = 0;
  logic [7:0] ctl_data = '0;
  int         lat = 0;
  int         wr_total = 0, rd_total = 0;
  int         since_start = 0, min_gap = 1000;
  bit         have_prev = 1'b0;
  int         rd_log [$];

  always @(negedge clk) begin
    writing_finished = 1'b0;
    data_ready       = 1'b0;
    since_start++;
    if (!reset_n) have_prev = 1'b0;
    if (start_operation) begin
      if (have_prev && since_start < min_gap) min_gap = since_start;
      since_start = 0;
      have_prev   = 1'b1;
      if (rw) begin rd_total++; rd_log.push_back(int'(address)); end
      else wr_total++;
    end
    if (ctl_busy) begin
      lat--;
      if (lat == 0) begin
        ctl_busy  = 1'b0;
        busy_ctrl = 1'b0;
        if (!ctl_rw) begin
          mem[ctl_addr] = ctl_data;
          if (!hang_wr) writing_finished = 1'b1;
        end else begin
          data_s2f   = faulty.exists(ctl_addr) ? 8'h00 :
                       (mem.exists(ctl_addr) ? mem[ctl_addr] : 8'h00);
          data_ready = 1'b1;
        end
      end
    end else if (start_operation) begin
      ctl_busy  = 1'b1;
      busy_ctrl = 1'b1;
      lat       = $urandom_range(2, 5);
      ctl_rw    = rw;
      ctl_addr  = int'(address);
      ctl_data  = data_f2s;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, ":ctl"}, {26'd0, start_operation, rw, test_busy, test_done, test_pass, timeout_err}, 32'd0);
    check_eq({tag, ":address"}, 32'(address), 32'd0);
    check_eq({tag, ":data_f2s"}, 32'(data_f2s), 32'd0);
    check_eq({tag, ":err_count"}, 32'(err_count), 32'd0);
    check_eq({tag, ":first_err"}, 32'(first_err_addr), 32'd0);
  endtask

  task automatic start_run(input int lo, input int hi, input logic [7:0] sd);
    @(negedge clk);
    addr_lo = lo[AW-1:0];
    addr_hi = hi[AW-1:0];
    seed    = sd;
    run     = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  // Runs one test and compares against outcomes derived from the window, seed and fault set.
  task automatic run_and_check(input string name, input int lo, input int hi, input logic [7:0] sd);
    int  exp_err, exp_first, exp_rd, exp_last, n, wr0, rd0, cyc;
    bit  ok;
    logic [7:0] got;
    exp_err = 0; exp_first = 0; exp_rd = 0; exp_last = 0;
    n = (hi >= lo) ? hi - lo + 1 : 0;
    for (int a = lo; a <= hi; a++) begin
      exp_rd++;
      exp_last = a;
      got = faulty.exists(a) ? 8'h00 : ref_pat(a, sd);
      if (got != ref_pat(a, sd)) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
`ifdef SRAM_TEST_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    wr0 = wr_total;
    rd0 = rd_total;
    start_run(lo, hi, sd);
    check_eq({name, ":busy"}, 32'(test_busy), 32'd1);
    cyc = 0;
    while (test_done !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({name, ":done"}, 32'(test_done), 32'd1);
    if (n == 0) check_eq({name, ":done_fast"}, 32'(cyc <= 3), 32'd1);
    check_eq({name, ":pass"}, 32'(test_pass), 32'(exp_err == 0));
    check_eq({name, ":err_count"}, 32'(err_count), 32'(exp_err));
    check_eq({name, ":first_err"}, 32'(first_err_addr), 32'(exp_first));
    check_eq({name, ":timeout"}, 32'(timeout_err), 32'd0);
    check_eq({name, ":busy_end"}, 32'(test_busy), 32'd0);
    check_eq({name, ":writes"}, 32'(wr_total - wr0), 32'(n));
    check_eq({name, ":reads"}, 32'(rd_total - rd0), 32'(exp_rd));
    if (exp_rd > 0) check_eq({name, ":last_rd"}, 32'(rd_log[rd_log.size()-1]), 32'(exp_last));
    check_eq({name, ":spacing"}, 32'(min_gap >= 6), 32'd1);
    if (n > 0) begin
      ok = 1'b1;
      for (int a = lo; a <= hi; a++)
        if (!mem.exists(a) || mem[a] !== ref_pat(a, sd)) ok = 1'b0;
      check_eq({name, ":mem"}, 32'(ok), 32'd1);
    end
    @(negedge clk);
    check_eq({name, ":done_pulse"}, 32'(test_done), 32'd0);
  endtask

  initial begin
    int cyc, lo, sz;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_and_check("basic", 0, 15, 8'hA5);

    faulty[7] = 1'b1;
    run_and_check("fault7", 0, 15, 8'hA5);
    faulty.delete();

    faulty[3] = 1'b1;
    faulty[9] = 1'b1;
    run_and_check("two_faults", 0, 15, 8'hA5);
    faulty.delete();

    run_and_check("empty", 16, 15, 8'h3C);
    run_and_check("single", 32'h123, 32'h123, 8'h5A);

    // Write completion never arrives: timeout abort.
    hang_wr = 1'b1;
    start_run(0, 15, 8'h11);
    cyc = 0;
    while (start_operation !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    check_eq("to:start", 32'(start_operation), 32'd1);
    cyc = 0;
    while (test_done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    check_eq("to:done", 32'(test_done), 32'd1);
    check_eq("to:latency", 32'(cyc >= 16 && cyc <= 18), 32'd1);
    check_eq("to:timeout_err", 32'(timeout_err), 32'd1);
    check_eq("to:pass", 32'(test_pass), 32'd0);
    hang_wr = 1'b0;
    repeat (10) @(negedge clk);

    // Reset during a read of a 0x100-word test.
    start_run(0, 255, 8'h77);
    cyc = 0;
    while (!(start_operation === 1'b1 && rw === 1'b1) && cyc < 20000) begin @(negedge clk); cyc++; end
    check_eq("rst:rd_seen", 32'(start_operation && rw), 32'd1);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    run_and_check("after_rst", 0, 31, 8'h77);

    for (int t = 0; t < 6; t++) begin
      sz = $urandom_range(1, 24);
      lo = $urandom_range(0, 32'h7FF00);
      for (int f = $urandom_range(0, 3); f > 0; f--)
        faulty[lo + $urandom_range(0, sz - 1)] = 1'b1;
      run_and_check($sformatf("rand%0d", t), lo, lo + sz - 1, 8'($urandom));
      faulty.delete();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
